// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one MUL unit among N_REQ requesters.
// Optional busy-cycle counter enabled by defining MUL_SCHED_BUSYCNT_EN.
module mul_sched #(
  parameter int N_REQ   = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [31:0]          mul_in1,
  output logic [31:0]          mul_in2,
  input  logic [31:0]          mul_result,
  input  logic [3:0]           mul_flag,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [31:0]          resp_result,
  output logic [3:0]           resp_flag
`ifdef MUL_SCHED_BUSYCNT_EN
  ,
  output logic [31:0]          busy_cycles
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     gid_q, gid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       mul_in1_q, mul_in1_d;
  logic [31:0]       mul_in2_q, mul_in2_d;
  logic [31:0]       resp_result_q, resp_result_d;
  logic [3:0]        resp_flag_q, resp_flag_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [N_REQ-1:0]  req_ready_s;

  logic              grant_vld_s;
  logic [PW-1:0]     grant_s;
  logic [31:0]       grant_a_s;
  logic [31:0]       grant_b_s;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int idx;
    grant_vld_s = 1'b0;
    grant_s     = '0;
    grant_a_s   = 32'd0;
    grant_b_s   = 32'd0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_vld_s && req_valid[idx]) begin
        grant_vld_s = 1'b1;
        grant_s     = PW'(idx);
        grant_a_s   = req_a[32*idx +: 32];
        grant_b_s   = req_b[32*idx +: 32];
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/WAIT/DONE sequence.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gid_d         = gid_q;
    cnt_d         = cnt_q;
    mul_in1_d     = mul_in1_q;
    mul_in2_d     = mul_in2_q;
    resp_result_d = resp_result_q;
    resp_flag_d   = resp_flag_q;
    resp_valid_d  = '0;
    req_ready_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          // Ready is only raised for a valid requester, so a grant is a handshake.
          req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_s;
          mul_in1_d   = grant_a_s;
          mul_in2_d   = grant_b_s;
          gid_d       = grant_s;
          cnt_d       = CW'(MUL_LAT - 1);
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          resp_result_d = mul_result;
          resp_flag_d   = mul_flag;
          resp_valid_d  = {{(N_REQ-1){1'b0}}, 1'b1} << gid_q;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (gid_q == PW'(N_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gid_q + {{(PW-1){1'b0}}, 1'b1};
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      gid_q         <= '0;
      cnt_q         <= '0;
      mul_in1_q     <= 32'd0;
      mul_in2_q     <= 32'd0;
      resp_result_q <= 32'd0;
      resp_flag_q   <= 4'd0;
      resp_valid_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gid_q         <= gid_d;
      cnt_q         <= cnt_d;
      mul_in1_q     <= mul_in1_d;
      mul_in2_q     <= mul_in2_d;
      resp_result_q <= resp_result_d;
      resp_flag_q   <= resp_flag_d;
      resp_valid_q  <= resp_valid_d;
    end
  end

  assign req_ready   = req_ready_s;
  assign mul_in1     = mul_in1_q;
  assign mul_in2     = mul_in2_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flag   = resp_flag_q;

`ifdef MUL_SCHED_BUSYCNT_EN
  logic [31:0] busy_q, busy_d;

  // Count every cycle spent outside IDLE; wraps naturally.
  always_comb begin
    if (state_q != ST_IDLE) begin
      busy_d = busy_q + 32'd1;
    end else begin
      busy_d = busy_q;
    end
  end

  // Busy counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_mul_sched.sv
// Directed self-checking bench for mul_sched (N_REQ=2, MUL_LAT=2) with a delayed MUL model.
module tb_mul_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic [31:0] mul_in1, mul_in2, mul_result, resp_result;
  logic [3:0]  mul_flag, resp_flag;
  logic [1:0]  resp_valid;
`ifdef MUL_SCHED_BUSYCNT_EN
  logic [31:0] busy_cycles;
`endif

  int checks = 0;
  int passed = 0;
  int both_cnt = 0;

  mul_sched #(.N_REQ(2), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_result(mul_result), .mul_flag(mul_flag),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_flag(resp_flag)
`ifdef MUL_SCHED_BUSYCNT_EN
    , .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  // MUL model: product appears one clock after the operands change (settles within 2 cycles).
  logic [31:0] prod_q = 32'd0;
  always @(posedge clk) prod_q <= mul_in1 * mul_in2;
  assign mul_result = prod_q;
  assign mul_flag   = prod_q[3:0] ^ 4'hA;

  always @(negedge clk) if (resp_valid == 2'b11) both_cnt++;

  task automatic apply_reset();
    req_valid = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) at negedges for a response; n = negedges waited.
  task automatic wait_resp(output logic [1:0] v, output logic [31:0] r,
                           output logic [3:0] f, output int n);
    v = 2'b00; r = 32'd0; f = 4'd0; n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00) begin
        v = resp_valid; r = resp_result; f = resp_flag; n = i;
        return;
      end
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b exp 00", req_ready); else passed++;
    checks++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid got %b exp 00", resp_valid); else passed++;
    checks++; if (mul_in1 !== 32'd0 || mul_in2 !== 32'd0) $display("FAIL reset_mul_in got %0d/%0d exp 0/0", mul_in1, mul_in2); else passed++;
    checks++; if (resp_result !== 32'd0 || resp_flag !== 4'd0) $display("FAIL reset_resp got %0d/%0h exp 0/0", resp_result, resp_flag); else passed++;
    apply_reset();
  endtask

  task automatic test_single();
    logic [1:0] v; logic [31:0] r; logic [3:0] f; int n;
    req_a = {32'd0, 32'd2}; req_b = {32'd0, 32'd3}; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) $display("FAIL single_ready got %b exp 01", req_ready); else passed++;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (mul_in1 !== 32'd2 || mul_in2 !== 32'd3) $display("FAIL single_mul_in got %0d/%0d exp 2/3", mul_in1, mul_in2); else passed++;
    checks++; if (req_ready !== 2'b00) $display("FAIL single_ready_wait got %b exp 00", req_ready); else passed++;
    wait_resp(v, r, f, n);
    // Handshake edge was one edge before the first negedge sampled above.
    checks++; if (n !== 2) $display("FAIL single_latency got %0d exp 2", n); else passed++;
    checks++; if (v !== 2'b01 || r !== 32'd6 || f !== 4'hC) $display("FAIL single_resp got %b/%0d/%h exp 01/6/c", v, r, f); else passed++;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) $display("FAIL single_pulse got %b exp 00", resp_valid); else passed++;
  endtask

  task automatic test_contention();
    logic [1:0] v; logic [31:0] r; logic [3:0] f; int n;
    apply_reset();
    both_cnt = 0;
    req_a = {32'd10, 32'd5}; req_b = {32'd10, 32'd9}; req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) $display("FAIL contend_grant got %b exp 01", req_ready); else passed++;
    wait_resp(v, r, f, n);
    checks++; if (v !== 2'b01 || r !== 32'd45 || f !== 4'h7) $display("FAIL contend_first got %b/%0d/%h exp 01/45/7", v, r, f); else passed++;
    wait_resp(v, r, f, n);
    req_valid = 2'b00;
    checks++; if (v !== 2'b10 || r !== 32'd100 || f !== 4'hE) $display("FAIL contend_second got %b/%0d/%h exp 10/100/e", v, r, f); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (both_cnt !== 0) $display("FAIL contend_both got %0d exp 0", both_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] v; logic [31:0] r; logic [3:0] f; int n;
    logic [1:0]  exp_v [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_r [4] = '{32'd6, 32'd3, 32'd12, 32'd60};
    apply_reset();
    req_a = {32'd1, 32'd2}; req_b = {32'd3, 32'd3}; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_resp(v, r, f, n);
      if (k == 0) begin req_a[31:0] = 32'd6; req_b[31:0] = 32'd2; end
      if (k == 1) begin req_a[63:32] = 32'd10; req_b[63:32] = 32'd6; end
      if (k == 3) req_valid = 2'b00;
      checks++; if (v !== exp_v[k] || r !== exp_r[k]) $display("FAIL b2b_op%0d got %b/%0d exp %b/%0d", k, v, r, exp_v[k], exp_r[k]); else passed++;
      // From DONE, the next response takes IDLE + 2 WAIT + DONE = 4 negedges.
      if (k > 0) begin
        checks++; if (n !== 4) $display("FAIL b2b_gap%0d got %0d exp 4", k, n); else passed++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    logic [1:0] v; logic [31:0] r; logic [3:0] f; int n;
    req_a = {32'd10, 32'd0}; req_b = {32'd6, 32'd0}; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    checks++; if (mul_in1 !== 32'd0 || mul_in2 !== 32'd0 || req_ready !== 2'b00) $display("FAIL rstwait_mul_in got %0d/%0d/%b exp 0/0/00", mul_in1, mul_in2, req_ready); else passed++;
    checks++; if (resp_valid !== 2'b00 || resp_result !== 32'd0 || resp_flag !== 4'd0) $display("FAIL rstwait_resp got %b/%0d/%h exp 00/0/0", resp_valid, resp_result, resp_flag); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_resp(v, r, f, n);
    checks++; if (n !== -1) $display("FAIL rstwait_no_resp got %b after %0d exp none", v, n); else passed++;
    req_a = {32'd0, 32'd1}; req_b = {32'd0, 32'd3}; req_valid = 2'b01;
    wait_resp(v, r, f, n);
    req_valid = 2'b00;
    checks++; if (v !== 2'b01 || r !== 32'd3 || f !== 4'h9) $display("FAIL rstwait_next got %b/%0d/%h exp 01/3/9", v, r, f); else passed++;
    @(negedge clk);
  endtask

  task automatic test_operand_hold();
    logic [1:0] v; logic [31:0] r; logic [3:0] f; int n;
    req_a = {32'd0, 32'd2}; req_b = {32'd0, 32'd3}; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    req_a = {32'd0, 32'd7};
    @(negedge clk);
    checks++; if (mul_in1 !== 32'd2) $display("FAIL hold_mul_in1 got %0d exp 2", mul_in1); else passed++;
    wait_resp(v, r, f, n);
    checks++; if (v !== 2'b01 || r !== 32'd6) $display("FAIL hold_resp got %b/%0d exp 01/6", v, r); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (mul_in1 !== 32'd2 || mul_in2 !== 32'd3) $display("FAIL hold_idle got %0d/%0d exp 2/3", mul_in1, mul_in2); else passed++;
  endtask

`ifdef MUL_SCHED_BUSYCNT_EN
  task automatic test_busycnt();
    logic [1:0] v; logic [31:0] r; logic [3:0] f; int n;
    logic [31:0] b0;
    b0 = busy_cycles;
    repeat (3) @(negedge clk);
    checks++; if (busy_cycles !== b0) $display("FAIL busy_idle got %0d exp %0d", busy_cycles, b0); else passed++;
    req_a = {32'd0, 32'd4}; req_b = {32'd0, 32'd4}; req_valid = 2'b01;
    wait_resp(v, r, f, n);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (busy_cycles !== b0 + 32'd3) $display("FAIL busy_op got %0d exp %0d", busy_cycles, b0 + 32'd3); else passed++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_inflight();
    test_operand_hold();
`ifdef MUL_SCHED_BUSYCNT_EN
    test_busycnt();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
